// File: rtl/shift_multi_seq.sv
// rtl/shift_multi_seq.sv - sequential multi-bit shifter for RRCM/RRAM/RLAM/RRUM
// One bit per clock, 1-4 positions per command; result and flags register on the final step.
module shift_multi_seq #(
  parameter int SIZE_BYTE = 8,
  parameter int SIZE_WORD = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic [1:0]           FS,
  input  logic                 BW,
  input  logic [1:0]           CNT,
  input  logic                 CIN,
  input  logic [SIZE_WORD-1:0] DST,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [SIZE_WORD-1:0] SHIFT_OUT,
  output logic [3:0]           CVNZ_shift
);

  localparam logic [1:0] OP_RRCM = 2'b00;
  localparam logic [1:0] OP_RRAM = 2'b01;
  localparam logic [1:0] OP_RLAM = 2'b10;
  localparam logic [SIZE_WORD-1:0] BYTE_MASK =
    {{(SIZE_WORD-SIZE_BYTE){1'b0}}, {SIZE_BYTE{1'b1}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [1:0]           fs_q;
  logic                 bw_q;
  logic                 carry_q;
  logic [2:0]           remaining_q;
  logic [SIZE_WORD-1:0] work_q;
  logic                 done_q;

  logic                 load, step, last;
  logic                 fill;
  logic [SIZE_WORD-1:0] step_val;
  logic                 step_c;
  logic                 res_n, res_z;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (remaining_q == 3'd1) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single-position step of the working register; byte mode keeps the upper byte zero.
  always_comb begin
    fill     = 1'b0;
    step_val = work_q;
    step_c   = carry_q;
    if (fs_q == OP_RLAM) begin
      step_val = {work_q[SIZE_WORD-2:0], 1'b0};
      step_c   = bw_q ? work_q[SIZE_BYTE-1] : work_q[SIZE_WORD-1];
    end else begin
      case (fs_q)
        OP_RRCM: fill = carry_q;
        OP_RRAM: fill = bw_q ? work_q[SIZE_BYTE-1] : work_q[SIZE_WORD-1];
        default: fill = 1'b0;
      endcase
      step_val = work_q >> 1;
      if (bw_q) step_val[SIZE_BYTE-1] = fill;
      else      step_val[SIZE_WORD-1] = fill;
      step_c = work_q[0];
    end
    if (bw_q) step_val = step_val & BYTE_MASK;
    res_n = bw_q ? step_val[SIZE_BYTE-1] : step_val[SIZE_WORD-1];
    res_z = bw_q ? (step_val[SIZE_BYTE-1:0] == '0) : (step_val == '0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fs_q        <= 2'b00;
      bw_q        <= 1'b0;
      carry_q     <= 1'b0;
      remaining_q <= 3'd0;
      work_q      <= '0;
      done_q      <= 1'b0;
      SHIFT_OUT   <= '0;
      CVNZ_shift  <= 4'b0000;
    end else begin
      done_q <= last;
      if (load) begin
        fs_q        <= FS;
        bw_q        <= BW;
        carry_q     <= CIN;
        remaining_q <= {1'b0, CNT} + 3'd1;
        work_q      <= BW ? (DST & BYTE_MASK) : DST;
      end else if (step) begin
        work_q      <= step_val;
        carry_q     <= step_c;
        remaining_q <= remaining_q - 3'd1;
      end
      if (last) begin
        SHIFT_OUT  <= step_val;
        CVNZ_shift <= {step_c, 1'b0, res_n, res_z};
      end
    end
  end

  assign BUSY = (state_q == RUN);
  assign DONE = done_q;

endmodule

// File: tb/tb_shift_multi_seq.sv
// tb/tb_shift_multi_seq.sv - directed, table-driven bench for shift_multi_seq
module tb_shift_multi_seq;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic [1:0]  FS;
  logic        BW;
  logic [1:0]  CNT;
  logic        CIN;
  logic [15:0] DST;
  logic        BUSY;
  logic        DONE;
  logic [15:0] SHIFT_OUT;
  logic [3:0]  CVNZ_shift;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] prev_out  = 16'h0000;
  logic [3:0]  prev_cvnz = 4'b0000;

  typedef struct {
    logic [1:0]  fs;
    logic        bw;
    logic [1:0]  cnt;
    logic        cin;
    logic [15:0] dst;
    logic [15:0] exp_out;
    logic [3:0]  exp_cvnz;
  } vec_t;

  vec_t vecs[9];

  shift_multi_seq #(.SIZE_BYTE(8), .SIZE_WORD(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .FS(FS), .BW(BW), .CNT(CNT),
    .CIN(CIN), .DST(DST), .BUSY(BUSY), .DONE(DONE), .SHIFT_OUT(SHIFT_OUT),
    .CVNZ_shift(CVNZ_shift)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issues one command, scrambles the inputs after acceptance and checks every cycle to DONE.
  task automatic run_cmd(input string name, input logic [1:0] fs, input logic bw,
                         input logic [1:0] cnt, input logic cin, input logic [15:0] dst,
                         input logic [15:0] eo, input logic [3:0] ec);
    FS = fs; BW = bw; CNT = cnt; CIN = cin; DST = dst; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; FS = ~fs; BW = ~bw; CNT = ~cnt; CIN = ~cin; DST = ~dst;
    for (int i = 0; i <= int'(cnt); i++) begin
      check({name, " busy"}, {31'd0, BUSY}, 32'd1);
      check({name, " no early done"}, {31'd0, DONE}, 32'd0);
      check({name, " out held"}, {16'd0, SHIFT_OUT}, {16'd0, prev_out});
      check({name, " cvnz held"}, {28'd0, CVNZ_shift}, {28'd0, prev_cvnz});
      @(posedge CLK); #1;
    end
    check({name, " done"}, {31'd0, DONE}, 32'd1);
    check({name, " busy low"}, {31'd0, BUSY}, 32'd0);
    check({name, " out"}, {16'd0, SHIFT_OUT}, {16'd0, eo});
    check({name, " cvnz"}, {28'd0, CVNZ_shift}, {28'd0, ec});
    prev_out  = eo;
    prev_cvnz = ec;
  endtask

  task automatic idle_cycle(input string name);
    @(posedge CLK); #1;
    check({name, " done pulse ends"}, {31'd0, DONE}, 32'd0);
    check({name, " idle"}, {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    //            fs     bw    cnt    cin   dst       out       cvnz
    vecs[0] = '{2'b10, 1'b0, 2'b11, 1'b0, 16'h8421, 16'h4210, 4'b0000};
    vecs[1] = '{2'b01, 1'b1, 2'b01, 1'b0, 16'h1285, 16'h00E1, 4'b0010};
    vecs[2] = '{2'b00, 1'b0, 2'b10, 1'b0, 16'h0005, 16'h4000, 4'b1000};
    vecs[3] = '{2'b11, 1'b0, 2'b00, 1'b0, 16'h0001, 16'h0000, 4'b1001};
    vecs[4] = '{2'b00, 1'b1, 2'b00, 1'b1, 16'h0000, 16'h0080, 4'b0010};
    vecs[5] = '{2'b11, 1'b1, 2'b11, 1'b0, 16'hFF0F, 16'h0000, 4'b1001};
    vecs[6] = '{2'b01, 1'b0, 2'b11, 1'b0, 16'h8000, 16'hF800, 4'b0010};
    vecs[7] = '{2'b10, 1'b1, 2'b11, 1'b0, 16'h12F1, 16'h0010, 4'b1000};
    vecs[8] = '{2'b00, 1'b0, 2'b11, 1'b1, 16'h0000, 16'h1000, 4'b0000};

    RST_N = 1'b0; START = 1'b0; FS = 2'b00; BW = 1'b0; CNT = 2'b00; CIN = 1'b0; DST = 16'h0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset busy", {31'd0, BUSY}, 32'd0);
    check("reset done", {31'd0, DONE}, 32'd0);
    check("reset out", {16'd0, SHIFT_OUT}, 32'd0);
    check("reset cvnz", {28'd0, CVNZ_shift}, 32'd0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    for (int v = 0; v < 9; v++) begin
      run_cmd($sformatf("vec%0d", v), vecs[v].fs, vecs[v].bw, vecs[v].cnt, vecs[v].cin,
              vecs[v].dst, vecs[v].exp_out, vecs[v].exp_cvnz);
      idle_cycle($sformatf("vec%0d", v));
    end

    // Back-to-back: second START lands in the DONE cycle of the first.
    run_cmd("b2b rrum", 2'b11, 1'b0, 2'b00, 1'b0, 16'h0001, 16'h0000, 4'b1001);
    run_cmd("b2b rlam", 2'b10, 1'b1, 2'b00, 1'b0, 16'h0080, 16'h0000, 4'b1001);
    idle_cycle("b2b");

    // START pulsed mid-run with different operands must be ignored.
    FS = 2'b10; BW = 1'b0; CNT = 2'b11; CIN = 1'b0; DST = 16'h8421; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); #1;
    FS = 2'b00; CIN = 1'b1; DST = 16'hFFFF; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    check("midstart busy", {31'd0, BUSY}, 32'd1);
    @(posedge CLK); #1;
    check("midstart not yet done", {31'd0, DONE}, 32'd0);
    @(posedge CLK); #1;
    check("midstart done on time", {31'd0, DONE}, 32'd1);
    check("midstart out", {16'd0, SHIFT_OUT}, 32'h4210);
    check("midstart cvnz", {28'd0, CVNZ_shift}, 32'h0);
    prev_out = 16'h4210; prev_cvnz = 4'b0000;
    idle_cycle("midstart");

    // Reset after two steps of a four-step command aborts it.
    FS = 2'b10; BW = 1'b0; CNT = 2'b11; CIN = 1'b0; DST = 16'h0F0F; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    check("abort busy", {31'd0, BUSY}, 32'd0);
    check("abort done", {31'd0, DONE}, 32'd0);
    check("abort out", {16'd0, SHIFT_OUT}, 32'd0);
    check("abort cvnz", {28'd0, CVNZ_shift}, 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    prev_out = 16'h0000; prev_cvnz = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      check("abort no late done", {31'd0, DONE}, 32'd0);
      @(posedge CLK); #1;
    end
    run_cmd("after abort", 2'b01, 1'b1, 2'b01, 1'b0, 16'h1285, 16'h00E1, 4'b0010);
    idle_cycle("after abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
